// File: rtl/fifo_rd_stage.sv
// Read-side consumer of the FIFO pointer controller: owns the read pointer,
// strobes the synchronous-read storage and presents each word on a valid/ready stream.
module fifo_rd_stage #(
  parameter int width  = 1,
  parameter int dwidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              empty_i,
  input  logic              r_busy_i,
  input  logic [width:0]    r_ptr_next_i,
  output logic [width:0]    r_ptr_o,
  output logic              rd_en_o,
  output logic [width:0]    rd_addr_o,
  input  logic [dwidth-1:0] rd_data_i,
  output logic [dwidth-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [15:0]       pops_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t state;
  logic   can_read;

  assign can_read = !empty_i && !r_busy_i;

  // Storage samples this at the issue edge, i.e. the pre-advance pointer.
  assign rd_addr_o = r_ptr_o;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would make the update order matter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      r_ptr_o <= '0;
      rd_en_o <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
      pops_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (can_read) begin
            rd_en_o <= 1'b1;
            r_ptr_o <= r_ptr_next_i;
            state   <= FETCH;
          end
        end

        FETCH: begin
          rd_en_o <= 1'b0;
          data_o  <= rd_data_i;
          valid_o <= 1'b1;
          state   <= HOLD;
        end

        HOLD: begin
          // valid_o is always high here, so ready_i alone marks an accept.
          if (ready_i) begin
            pops_o  <= pops_o + 16'd1;
            valid_o <= 1'b0;
            if (can_read) begin
              rd_en_o <= 1'b1;
              r_ptr_o <= r_ptr_next_i;
              state   <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          rd_en_o <= 1'b0;
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Bench for fifo_rd_stage: models a size-5 controller/storage, pushes expected
// read addresses and data into queues, and a negedge monitor checks the outputs.
module tb_fifo_rd_stage;

  localparam int W    = 2;
  localparam int DW   = 8;
  localparam int SIZE = 5;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          empty_i;
  logic          r_busy_i;
  logic [W:0]    r_ptr_next_i;
  logic [W:0]    r_ptr_o;
  logic          rd_en_o;
  logic [W:0]    rd_addr_o;
  logic [DW-1:0] rd_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [15:0]   pops_o;

  fifo_rd_stage #(.width(W), .dwidth(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .empty_i(empty_i), .r_busy_i(r_busy_i),
    .r_ptr_next_i(r_ptr_next_i), .r_ptr_o(r_ptr_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .pops_o(pops_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller and storage model
  logic [DW-1:0] mem [SIZE];
  logic [W:0]    wr_ptr;
  logic [W:0]    rs1, rs2;
  logic          busy_force;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rs1 <= '0;
      rs2 <= '0;
    end else begin
      rs1 <= r_ptr_o;
      rs2 <= rs1;
    end
  end

  always_ff @(posedge clk_i)
    rd_data_i <= (int'(rd_addr_o) < SIZE) ? mem[int'(rd_addr_o)] : '0;

  assign r_ptr_next_i = (int'(r_ptr_o) == SIZE - 1) ? '0 : r_ptr_o + 1'b1;
  assign empty_i      = (wr_ptr == rs2);
  assign r_busy_i     = (rs2 != r_ptr_o) || busy_force;

  // Scoreboard
  logic [W:0]    exp_addr [$];
  logic [DW-1:0] exp_data [$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[int'(wr_ptr)] = d;
    exp_addr.push_back(wr_ptr);
    exp_data.push_back(d);
    wr_ptr = (int'(wr_ptr) == SIZE - 1) ? '0 : wr_ptr + 1'b1;
  endtask

  function automatic int occupancy();
    return (int'(wr_ptr) + SIZE - int'(rs2)) % SIZE;
  endfunction

  task automatic do_reset();
    rst_n_i    = 1'b0;
    wr_ptr     = '0;
    ready_i    = 1'b0;
    busy_force = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    repeat (3) step();
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_data.size() != 0 || valid_o) && n < 300) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, n < 300, 1);
  endtask

  // Monitor
  int            n_acc = 0;
  int            rd_cnt = 0;
  logic          acc_pending = 1'b0;
  logic          prev_rd_en = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [W:0]    prev_addr = '0;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      n_acc       = 0;
      rd_cnt      = 0;
      acc_pending = 1'b0;
      prev_rd_en  = 1'b0;
      prev_hold   = 1'b0;
      prev_addr   = '0;
    end else begin
      if (acc_pending) check("pops_count", pops_o, n_acc);
      acc_pending = 1'b0;
      if (prev_hold) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", data_o, prev_data);
      end
      if (rd_en_o) begin
        check("rd_en_single_cycle", prev_rd_en, 0);
        rd_cnt++;
        if (exp_addr.size() == 0) check("rd_addr_unexpected", 1, 0);
        else check("rd_addr", prev_addr, exp_addr.pop_front());
      end
      if (valid_o && ready_i) begin
        if (exp_data.size() == 0) check("data_unexpected", 1, 0);
        else check("data", data_o, exp_data.pop_front());
        n_acc++;
        acc_pending = 1'b1;
      end
      prev_hold  = valid_o && !ready_i;
      prev_data  = data_o;
      prev_rd_en = rd_en_o;
      prev_addr  = rd_addr_o;
    end
  end

  initial begin
    // Reset held while a word looks readable
    rst_n_i    = 1'b0;
    ready_i    = 1'b1;
    busy_force = 1'b0;
    wr_ptr     = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rst_r_ptr", r_ptr_o, 0);
      check("rst_rd_en", rd_en_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_pops", pops_o, 0);
      check("rst_data", data_o, 0);
    end
    step();
    wr_ptr  = '0;
    rst_n_i = 1'b1;
    repeat (3) step();
    check("idle_r_ptr", r_ptr_o, 0);
    check("idle_rd_cnt", rd_cnt, 0);

    // Single word, latency
    do_reset();
    ready_i = 1'b1;
    step();
    push(8'hA5);
    @(negedge clk_i);
    check("lat_rd_en_before", rd_en_o, 0);
    @(negedge clk_i);
    check("lat_rd_en_issue", rd_en_o, 1);
    check("lat_valid_issue", valid_o, 0);
    check("lat_r_ptr", r_ptr_o, 1);
    @(negedge clk_i);
    check("lat_valid_fetch", valid_o, 1);
    check("lat_data_fetch", data_o, 8'hA5);
    check("lat_rd_en_fetch", rd_en_o, 0);
    @(negedge clk_i);
    check("single_valid_drop", valid_o, 0);
    wait_drain("single");
    repeat (4) step();
    check("single_r_ptr", r_ptr_o, 1);
    check("single_pops", pops_o, 1);
    check("single_rd_cnt", rd_cnt, 1);

    // Backpressure with three queued words
    do_reset();
    step(); push(8'h11);
    step(); push(8'h22);
    step(); push(8'h33);
    repeat (12) step();
    check("bp_valid", valid_o, 1);
    check("bp_data", data_o, 8'h11);
    check("bp_rd_cnt", rd_cnt, 1);
    ready_i = 1'b1;
    wait_drain("bp");
    repeat (4) step();
    check("bp_pops", pops_o, 3);
    check("bp_rd_cnt_final", rd_cnt, 3);
    check("bp_r_ptr", r_ptr_o, 3);

    // Wrap-around over twelve words
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int n = 0;
      while (occupancy() >= 4 && n < 100) begin
        step();
        n++;
      end
      push(8'(i));
      step();
    end
    wait_drain("wrap");
    repeat (4) step();
    check("wrap_r_ptr", r_ptr_o, 2);
    check("wrap_pops", pops_o, 12);
    check("wrap_rd_cnt", rd_cnt, 12);

    // Busy gating
    do_reset();
    ready_i    = 1'b1;
    busy_force = 1'b1;
    step();
    push(8'h3C);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("busy_no_rd_en", rd_en_o, 0);
    end
    step();
    busy_force = 1'b0;
    @(negedge clk_i);
    check("busy_release_before_edge", rd_en_o, 0);
    @(negedge clk_i);
    check("busy_release_issue", rd_en_o, 1);
    wait_drain("busy");

    // Reset during HOLD
    do_reset();
    step();
    push(8'h77);
    repeat (4) step();
    check("mid_valid_hold", valid_o, 1);
    check("mid_r_ptr_hold", r_ptr_o, 1);
    rst_n_i = 1'b0;
    #1;
    check("mid_valid_async", valid_o, 0);
    check("mid_r_ptr_async", r_ptr_o, 0);
    wr_ptr = '0;
    exp_addr.delete();
    exp_data.delete();
    repeat (2) step();
    rst_n_i = 1'b1;
    ready_i = 1'b1;
    step();
    push(8'h5C);
    wait_drain("mid");
    repeat (4) step();
    check("mid_pops", pops_o, 1);
    check("mid_rd_cnt", rd_cnt, 1);
    check("mid_r_ptr_final", r_ptr_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
